// File: rtl/ffbank_pkg.sv
// Shared definitions for the flip-flop bank controller: operation and state
// encodings, parameter limits and the INIT counter width helper.
package ffbank_pkg;

  // Supported parameter ranges.
  localparam int NBANK_MIN    = 2;
  localparam int NBANK_MAX    = 16;
  localparam int INIT_CYC_MIN = 1;
  localparam int INIT_CYC_MAX = 255;

  // Operation carried with each request.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,  // granted, no pulse
    OP_LOAD = 2'b01,  // clock-enable pulse
    OP_SET  = 2'b10,  // synchronous set pulse
    OP_CLR  = 2'b11   // synchronous clear pulse
  } op_e;

  // Controller state.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of a down-counter that must hold the value cyc (clamped to the
  // supported range so an out-of-range parameter cannot size it to zero).
  function automatic int cnt_width(input int cyc);
    int c;
    c = (cyc < INIT_CYC_MIN) ? INIT_CYC_MIN :
        (cyc > INIT_CYC_MAX) ? INIT_CYC_MAX : cyc;
    return (c < 2) ? 1 : $clog2(c + 1);
  endfunction

endpackage

// File: rtl/ffbank_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the
// request vector; the 'last' pointer remembers the most recent winner so
// that on contention the other requester is served. 'last' resets to 1 so
// requester 0 wins the first contention, and only moves when a grant issues.
module ffbank_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  // Pick the winner: a lone requester always wins, contention goes to the
  // requester that did not win most recently.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the latest winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/ffbank_ctrl.sv
// Sequencing and arbitration controller for a bank of set/reset flip-flops.
// After reset it drives srst all-ones for INIT_CYC cycles (busy high), then
// grants one request per cycle and turns it into a one-cycle ce, sset or
// srst pulse on the addressed bank. All outputs are registered.
//
// Optional feature: define FFBANK_CTRL_SOFTCLR_EN to add the soft_clr input,
// which re-runs the INIT clear sequence from RUN while keeping err and the
// arbiter pointer.
module ffbank_ctrl
  import ffbank_pkg::*;
#(
  parameter int NBANK    = 4,
  parameter int BW       = $clog2(NBANK),
  parameter int INIT_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FFBANK_CTRL_SOFTCLR_EN
  input  logic             soft_clr,
`endif
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [BW-1:0]    bank0,
  input  logic [BW-1:0]    bank1,
  output logic [1:0]       gnt,
  output logic [NBANK-1:0] ce,
  output logic [NBANK-1:0] sset,
  output logic [NBANK-1:0] srst,
  output logic             d_sel,
  output logic             busy,
  output logic             err
);

  localparam int          CW        = cnt_width(INIT_CYC);
  localparam logic [BW:0] NBANK_LIM = (BW + 1)'(NBANK);

  state_e           state;
  state_e           state_nxt;
  logic [CW-1:0]    cnt;
  logic             soft_clr_i;
  logic             run;
  logic [1:0]       arb_gnt;

  op_e              sel_op;
  logic [BW-1:0]    sel_bank;
  logic             bank_ok;
  logic [NBANK-1:0] onehot;

  logic [1:0]       gnt_nxt;
  logic [NBANK-1:0] ce_nxt;
  logic [NBANK-1:0] sset_nxt;
  logic [NBANK-1:0] srst_nxt;
  logic             d_sel_nxt;
  logic             busy_nxt;
  logic             err_nxt;

`ifdef FFBANK_CTRL_SOFTCLR_EN
  assign soft_clr_i = soft_clr;
`else
  assign soft_clr_i = 1'b0;
`endif

  assign run = (state == ST_RUN);

  // Requests are only arbitrated in RUN; during INIT they stay pending.
  ffbank_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (run),
    .gnt   (arb_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT on its last counted cycle so the first RUN cycle
  // can already arbitrate; soft clear sends RUN back to INIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (cnt <= CW'(1)) state_nxt = ST_RUN;
      ST_RUN:  if (soft_clr_i)    state_nxt = ST_INIT;
      default: state_nxt = ST_INIT;
    endcase
  end

  // INIT duration counter: counts down in INIT, reloaded on soft clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CW'(INIT_CYC);
    end else if (state == ST_INIT) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
    end else if (soft_clr_i) begin
      cnt <= CW'(INIT_CYC);
    end
  end

  // Select the winning requester's op/bank and decode the bank index.
  always_comb begin
    sel_op   = arb_gnt[1] ? op_e'(op1) : op_e'(op0);
    sel_bank = arb_gnt[1] ? bank1 : bank0;
    bank_ok  = ({1'b0, sel_bank} < NBANK_LIM);
    onehot   = '0;
    for (int i = 0; i < NBANK; i++) begin
      onehot[i] = (sel_bank == BW'(i));
    end
  end

  // Output decode: INIT forces the clear, RUN converts a grant into a pulse.
  always_comb begin
    gnt_nxt   = 2'b00;
    ce_nxt    = '0;
    sset_nxt  = '0;
    srst_nxt  = '0;
    d_sel_nxt = d_sel;
    busy_nxt  = 1'b0;
    err_nxt   = err;
    case (state)
      ST_INIT: begin
        srst_nxt = '1;
        busy_nxt = 1'b1;
      end
      ST_RUN: begin
        gnt_nxt = arb_gnt;
        if (arb_gnt != 2'b00) begin
          d_sel_nxt = arb_gnt[1];
          if (!bank_ok) begin
            err_nxt = 1'b1;
          end else begin
            case (sel_op)
              OP_LOAD: ce_nxt   = onehot;
              OP_SET:  sset_nxt = onehot;
              OP_CLR:  srst_nxt = onehot;
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= 2'b00;
      ce    <= '0;
      sset  <= '0;
      srst  <= '0;
      d_sel <= 1'b0;
      busy  <= 1'b1;
      err   <= 1'b0;
    end else begin
      gnt   <= gnt_nxt;
      ce    <= ce_nxt;
      sset  <= sset_nxt;
      srst  <= srst_nxt;
      d_sel <= d_sel_nxt;
      busy  <= busy_nxt;
      err   <= err_nxt;
    end
  end

endmodule
